// File: rtl/bip_control_if.sv
// bip_control_if: program-memory, data-RAM and datapath control bundle driven by the BIP sequencer.
// The master modport belongs to the sequencer. The slave modport belongs to the memories/datapath side.
interface bip_control_if #(
    parameter int NBITS_O  = 11,
    parameter int NBITS_D  = 16,
    parameter int NBITS_PC = 11
);
    logic [NBITS_D-1:0]  i_instr;
    logic [NBITS_PC-1:0] o_pc;
    logic                o_rd_prog;
    logic [1:0]          o_SelA;
    logic                o_SelB;
    logic                o_WrAcc;
    logic                o_Op;
    logic [NBITS_O-1:0]  o_Operand;
    logic                o_rd_ram;
    logic                o_wr_ram;
    logic                o_halt;

    modport master (
        input  i_instr,
        output o_pc, o_rd_prog, o_SelA, o_SelB, o_WrAcc, o_Op,
        output o_Operand, o_rd_ram, o_wr_ram, o_halt
    );

    modport slave (
        output i_instr,
        input  o_pc, o_rd_prog, o_SelA, o_SelB, o_WrAcc, o_Op,
        input  o_Operand, o_rd_ram, o_wr_ram, o_halt
    );
endinterface

// File: rtl/bip_control.sv
// bip_control: FETCH/DECODE/[MEM]/EXEC instruction sequencer for the BIP accumulator CPU.
// Optional macro BIP_STEP_EN adds an i_step input that gates each instruction fetch for single-stepping.
module bip_control #(
    parameter int NBITS_O  = 11,
    parameter int NBITS_E  = 5,
    parameter int NBITS_D  = 16,
    parameter int NBITS_PC = 11
) (
    input  logic          i_clock,
    input  logic          i_reset,
`ifdef BIP_STEP_EN
    input  logic          i_step,
`endif
    bip_control_if.master bus
);
    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] MEM    = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] HALT   = 3'd4;

    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;

    function automatic logic [1:0] selAFor(input logic [4:0] opc);
        case (opc)
            OP_LDI:                           selAFor = 2'b10;
            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: selAFor = 2'b01;
            default:                          selAFor = 2'b00;
        endcase
    endfunction

    function automatic logic selBFor(input logic [4:0] opc);
        case (opc)
            OP_ADDI, OP_SUBI: selBFor = 1'b1;
            default:          selBFor = 1'b0;
        endcase
    endfunction

    function automatic logic opFor(input logic [4:0] opc);
        case (opc)
            OP_SUB, OP_SUBI: opFor = 1'b1;
            default:         opFor = 1'b0;
        endcase
    endfunction

    function automatic logic wrAccFor(input logic [4:0] opc);
        case (opc)
            OP_LD, OP_LDI, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: wrAccFor = 1'b1;
            default:                                         wrAccFor = 1'b0;
        endcase
    endfunction

    function automatic logic needsMemFor(input logic [4:0] opc);
        case (opc)
            OP_LD, OP_ADD, OP_SUB: needsMemFor = 1'b1;
            default:               needsMemFor = 1'b0;
        endcase
    endfunction

    logic [2:0]          stateR;
    logic [NBITS_PC-1:0] pcR;
    logic [NBITS_D-1:0]  irR;
    logic                rdProgR, rdRamR, wrRamR, wrAccR, selBR, opR, haltR;
    logic [1:0]          selAR;

    logic [2:0]          nextState_s;
    logic [NBITS_E-1:0]  opcode_s;
    logic                nextRdProg_s, nextRdRam_s, nextWrRam_s, nextWrAcc_s;
    logic                nextSelB_s, nextOp_s, nextHalt_s;
    logic [1:0]          nextSelA_s;
    logic                waitGo_s, enterGo_s;

    // FETCH with rdProgR low is a waiting fetch: the read is only issued once fetching is allowed.
`ifdef BIP_STEP_EN
    assign waitGo_s  = i_step;
    assign enterGo_s = 1'b0;
`else
    assign waitGo_s  = 1'b1;
    assign enterGo_s = 1'b1;
`endif

    // Next-state and next-output decode; outputs are registered so they describe the coming cycle.
    always_comb begin
        if (stateR == DECODE) begin
            opcode_s = bus.i_instr[NBITS_D-1 -: NBITS_E];
        end else begin
            opcode_s = irR[NBITS_D-1 -: NBITS_E];
        end
        nextState_s  = stateR;
        nextRdProg_s = 1'b0;
        nextRdRam_s  = 1'b0;
        nextHalt_s   = 1'b0;
        case (stateR)
            FETCH: begin
                if (rdProgR) begin
                    nextState_s = DECODE;
                end else begin
                    nextState_s  = FETCH;
                    nextRdProg_s = waitGo_s;
                end
            end
            DECODE: begin
                if (opcode_s == OP_HLT) begin
                    nextState_s = HALT;
                    nextHalt_s  = 1'b1;
                end else if (needsMemFor(opcode_s)) begin
                    nextState_s = MEM;
                    nextRdRam_s = 1'b1;
                end else begin
                    nextState_s = EXEC;
                end
            end
            MEM:  nextState_s = EXEC;
            EXEC: begin
                nextState_s  = FETCH;
                nextRdProg_s = enterGo_s;
            end
            HALT: begin
                nextState_s = HALT;
                nextHalt_s  = 1'b1;
            end
            default: nextState_s = FETCH;
        endcase
        // Datapath selects are held across MEM and EXEC so the RAM read settles under the final mux setting.
        if ((nextState_s == MEM) || (nextState_s == EXEC)) begin
            nextSelA_s = selAFor(opcode_s);
            nextSelB_s = selBFor(opcode_s);
            nextOp_s   = opFor(opcode_s);
        end else begin
            nextSelA_s = 2'b00;
            nextSelB_s = 1'b0;
            nextOp_s   = 1'b0;
        end
        if (nextState_s == EXEC) begin
            nextWrAcc_s = wrAccFor(opcode_s);
            nextWrRam_s = (opcode_s == OP_STO);
        end else begin
            nextWrAcc_s = 1'b0;
            nextWrRam_s = 1'b0;
        end
    end

    // State, PC, IR and output registers.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            stateR  <= FETCH;
            pcR     <= {NBITS_PC{1'b0}};
            irR     <= {NBITS_D{1'b0}};
            rdProgR <= 1'b0;
            rdRamR  <= 1'b0;
            wrRamR  <= 1'b0;
            wrAccR  <= 1'b0;
            selAR   <= 2'b00;
            selBR   <= 1'b0;
            opR     <= 1'b0;
            haltR   <= 1'b0;
        end else begin
            stateR  <= nextState_s;
            if (stateR == DECODE) begin
                irR <= bus.i_instr;
            end
            if (stateR == EXEC) begin
                pcR <= pcR + NBITS_PC'(1);
            end
            rdProgR <= nextRdProg_s;
            rdRamR  <= nextRdRam_s;
            wrRamR  <= nextWrRam_s;
            wrAccR  <= nextWrAcc_s;
            selAR   <= nextSelA_s;
            selBR   <= nextSelB_s;
            opR     <= nextOp_s;
            haltR   <= nextHalt_s;
        end
    end

    assign bus.o_pc      = pcR;
    assign bus.o_rd_prog = rdProgR;
    assign bus.o_SelA    = selAR;
    assign bus.o_SelB    = selBR;
    assign bus.o_WrAcc   = wrAccR;
    assign bus.o_Op      = opR;
    assign bus.o_Operand = irR[NBITS_O-1:0];
    assign bus.o_rd_ram  = rdRamR;
    assign bus.o_wr_ram  = wrRamR;
    assign bus.o_halt    = haltR;
endmodule
